// File: rtl/mc_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mc_ctrl_pkg
// Description : Shared encodings for the multi-cycle MIPS control unit.
// Revision    : 1.0 - initial release
// ============================================================================
package mc_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4
    } state_e;

    localparam logic [5:0] c_OP_RTYPE = 6'b000000;
    localparam logic [5:0] c_OP_ORI   = 6'b001101;
    localparam logic [5:0] c_OP_LW    = 6'b100011;
    localparam logic [5:0] c_OP_SW    = 6'b101011;
    localparam logic [5:0] c_OP_BEQ   = 6'b000100;
    localparam logic [5:0] c_OP_LUI   = 6'b001111;
    localparam logic [5:0] c_OP_JAL   = 6'b000011;

    localparam logic [5:0] c_FN_NOP   = 6'b000000;
    localparam logic [5:0] c_FN_ADDU  = 6'b100001;
    localparam logic [5:0] c_FN_SUBU  = 6'b100011;
    localparam logic [5:0] c_FN_JR    = 6'b001000;

    localparam logic [2:0] c_ALU_ADD  = 3'd0;
    localparam logic [2:0] c_ALU_SUB  = 3'd1;
    localparam logic [2:0] c_ALU_OR   = 3'd2;

    localparam logic [1:0] c_NPC_PC4  = 2'd0;
    localparam logic [1:0] c_NPC_BR   = 2'd1;
    localparam logic [1:0] c_NPC_JUMP = 2'd2;
    localparam logic [1:0] c_NPC_REG  = 2'd3;

    localparam logic [1:0] c_GRF_SRC_MEM = 2'd0;
    localparam logic [1:0] c_GRF_SRC_ALU = 2'd1;
    localparam logic [1:0] c_GRF_SRC_LUI = 2'd2;
    localparam logic [1:0] c_GRF_SRC_PC4 = 2'd3;

    localparam logic [1:0] c_GRF_DST_RT = 2'd0;
    localparam logic [1:0] c_GRF_DST_RD = 2'd1;
    localparam logic [1:0] c_GRF_DST_RA = 2'd2;

    localparam logic [1:0] c_ALU_IN_IMM = 2'd0;
    localparam logic [1:0] c_ALU_IN_REG = 2'd1;

    localparam logic       c_EXT_ZERO = 1'b0;
    localparam logic       c_EXT_SIGN = 1'b1;

    // One bit per recognised instruction; at most one is set.
    typedef struct packed {
        logic nop;
        logic addu;
        logic subu;
        logic jr;
        logic ori;
        logic lw;
        logic sw;
        logic beq;
        logic lui;
        logic jal;
    } instr_cls_t;

endpackage
`default_nettype wire

// File: rtl/mc_ctrl_decode.sv
`default_nettype none
// ============================================================================
// Module      : mc_decode
// Description : Maps opcode/func to an instruction-class one-hot and an
//               illegal-instruction flag. Purely combinational.
// Revision    : 1.0 - initial release
// ============================================================================
module mc_decode
    import mc_ctrl_pkg::*;
(
    input  logic [5:0]  i_opcode,
    input  logic [5:0]  i_func,
    output instr_cls_t  o_cls,
    output logic        o_illegal
);

    always_comb begin
        o_cls     = '0;
        o_illegal = 1'b0;
        case (i_opcode)
            c_OP_RTYPE: begin
                // opcode 0 with func 0 is taken as the all-zero nop word
                case (i_func)
                    c_FN_NOP:  o_cls.nop  = 1'b1;
                    c_FN_ADDU: o_cls.addu = 1'b1;
                    c_FN_SUBU: o_cls.subu = 1'b1;
                    c_FN_JR:   o_cls.jr   = 1'b1;
                    default:   o_illegal  = 1'b1;
                endcase
            end
            c_OP_ORI: o_cls.ori = 1'b1;
            c_OP_LW:  o_cls.lw  = 1'b1;
            c_OP_SW:  o_cls.sw  = 1'b1;
            c_OP_BEQ: o_cls.beq = 1'b1;
            c_OP_LUI: o_cls.lui = 1'b1;
            c_OP_JAL: o_cls.jal = 1'b1;
            default:  o_illegal = 1'b1;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mc_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mc_ctrl
// Description : Multi-cycle MIPS control unit (FETCH/DECODE/EXEC/MEM/WB)
//               with optional MEM timeout and retired-instruction counter.
// Revision    : 1.0 - initial release
// ============================================================================
module mc_ctrl
    import mc_ctrl_pkg::*;
#(
    parameter int RETIRE_W    = 32,
    parameter int MEM_TIMEOUT = 0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [5:0]          opCode,
    input  logic [5:0]          func,
    input  logic                equalAlu,
    input  logic                memReady,
    output logic                irWriteEn,
    output logic                pcWriteEn,
    output logic [1:0]          npcSel,
    output logic                regWriteEn,
    output logic                memWriteEn,
    output logic                memReadEn,
    output logic [2:0]          aluOp,
    output logic                extOp,
    output logic [1:0]          aluInOp,
    output logic [1:0]          grfWriteOp,
    output logic [1:0]          grfWriteAddrOp,
    output logic                instrDone,
    output logic                illegal,
    output logic                memTimeout,
    output logic [2:0]          state,
    output logic [RETIRE_W-1:0] retired
);

    localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] c_WAIT_LAST =
        WAIT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

    state_e                 state_q, state_d;
    logic [RETIRE_W-1:0]    retired_q, retired_d;
    logic                   mem_timeout_q, mem_timeout_d;
    logic [WAIT_W-1:0]      wait_q, wait_d;

    instr_cls_t             w_cls;
    logic                   w_illegal;
    logic                   w_timeout_hit;

    mc_decode u_decode (
        .i_opcode  (opCode),
        .i_func    (func),
        .o_cls     (w_cls),
        .o_illegal (w_illegal)
    );

    // Abort fires in the MEM_TIMEOUT-th MEM cycle if memReady is still low.
    assign w_timeout_hit = (MEM_TIMEOUT != 0) && (state_q == ST_MEM) &&
                           (wait_q == c_WAIT_LAST) && !memReady;

    always_comb begin
        state_d       = state_q;
        wait_d        = '0;
        mem_timeout_d = mem_timeout_q | w_timeout_hit;
        retired_d     = retired_q + RETIRE_W'(instrDone);
        case (state_q)
            ST_FETCH:  state_d = ST_DECODE;
            ST_DECODE: begin
                if (w_cls.jal)                      state_d = ST_WB;
                else if (w_cls.nop || w_illegal)    state_d = ST_FETCH;
                else                                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                if (w_cls.lw || w_cls.sw)           state_d = ST_MEM;
                else if (w_cls.beq || w_cls.jr)     state_d = ST_FETCH;
                else                                state_d = ST_WB;
            end
            ST_MEM: begin
                if (memReady) begin
                    state_d = w_cls.lw ? ST_WB : ST_FETCH;
                end else if (w_timeout_hit) begin
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_MEM;
                    wait_d  = wait_q + WAIT_W'(1);
                end
            end
            ST_WB:     state_d = ST_FETCH;
            default:   state_d = ST_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= ST_FETCH;
            retired_q     <= '0;
            mem_timeout_q <= 1'b0;
            wait_q        <= '0;
        end else begin
            state_q       <= state_d;
            retired_q     <= retired_d;
            mem_timeout_q <= mem_timeout_d;
            wait_q        <= wait_d;
        end
    end

    always_comb begin
        irWriteEn      = 1'b0;
        pcWriteEn      = 1'b0;
        npcSel         = c_NPC_PC4;
        regWriteEn     = 1'b0;
        memWriteEn     = 1'b0;
        memReadEn      = 1'b0;
        aluOp          = c_ALU_ADD;
        extOp          = c_EXT_ZERO;
        aluInOp        = c_ALU_IN_IMM;
        grfWriteOp     = c_GRF_SRC_MEM;
        grfWriteAddrOp = c_GRF_DST_RT;
        instrDone      = 1'b0;
        illegal        = 1'b0;

        // IR still holds the previous word during FETCH, so selects stay idle
        if (state_q != ST_FETCH) begin
            if (w_cls.subu || w_cls.beq)                aluOp = c_ALU_SUB;
            else if (w_cls.ori)                         aluOp = c_ALU_OR;
            if (w_cls.lw || w_cls.sw || w_cls.beq)      extOp = c_EXT_SIGN;
            if (w_cls.addu || w_cls.subu || w_cls.beq)  aluInOp = c_ALU_IN_REG;
            if (w_cls.addu || w_cls.subu || w_cls.ori)  grfWriteOp = c_GRF_SRC_ALU;
            else if (w_cls.lui)                         grfWriteOp = c_GRF_SRC_LUI;
            else if (w_cls.jal)                         grfWriteOp = c_GRF_SRC_PC4;
            if (w_cls.addu || w_cls.subu)               grfWriteAddrOp = c_GRF_DST_RD;
            else if (w_cls.jal)                         grfWriteAddrOp = c_GRF_DST_RA;
        end

        case (state_q)
            ST_FETCH:  irWriteEn = 1'b1;
            ST_DECODE: begin
                illegal = w_illegal;
                if (w_cls.nop || w_illegal) begin
                    pcWriteEn = 1'b1;
                    instrDone = 1'b1;
                end
            end
            ST_EXEC: begin
                if (w_cls.beq) begin
                    pcWriteEn = 1'b1;
                    instrDone = 1'b1;
                    npcSel    = equalAlu ? c_NPC_BR : c_NPC_PC4;
                end else if (w_cls.jr) begin
                    pcWriteEn = 1'b1;
                    instrDone = 1'b1;
                    npcSel    = c_NPC_REG;
                end
            end
            ST_MEM: begin
                memWriteEn = w_cls.sw;
                memReadEn  = w_cls.lw;
                if (memReady && w_cls.sw) begin
                    pcWriteEn = 1'b1;
                    instrDone = 1'b1;
                end else if (w_timeout_hit) begin
                    pcWriteEn = 1'b1;
                end
            end
            ST_WB: begin
                regWriteEn = 1'b1;
                pcWriteEn  = 1'b1;
                instrDone  = 1'b1;
                npcSel     = w_cls.jal ? c_NPC_JUMP : c_NPC_PC4;
            end
            default: ;
        endcase

        if (!reset) begin
            irWriteEn  = 1'b0;
            pcWriteEn  = 1'b0;
            regWriteEn = 1'b0;
            memWriteEn = 1'b0;
            memReadEn  = 1'b0;
            instrDone  = 1'b0;
            illegal    = 1'b0;
        end
    end

    assign state      = state_q;
    assign retired    = retired_q;
    assign memTimeout = mem_timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_mc_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mc_ctrl
// Description : Directed self-checking bench for mc_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mc_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opCode, func;
    logic       equalAlu, memReady;
    logic       irWriteEn, pcWriteEn, regWriteEn, memWriteEn, memReadEn;
    logic [1:0] npcSel, aluInOp, grfWriteOp, grfWriteAddrOp;
    logic [2:0] aluOp, state;
    logic       extOp, instrDone, illegal, memTimeout;
    logic [3:0] retired;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mc_ctrl #(.RETIRE_W(4), .MEM_TIMEOUT(4)) dut (
        .clk(clk), .reset(reset), .opCode(opCode), .func(func),
        .equalAlu(equalAlu), .memReady(memReady),
        .irWriteEn(irWriteEn), .pcWriteEn(pcWriteEn), .npcSel(npcSel),
        .regWriteEn(regWriteEn), .memWriteEn(memWriteEn), .memReadEn(memReadEn),
        .aluOp(aluOp), .extOp(extOp), .aluInOp(aluInOp),
        .grfWriteOp(grfWriteOp), .grfWriteAddrOp(grfWriteAddrOp),
        .instrDone(instrDone), .illegal(illegal), .memTimeout(memTimeout),
        .state(state), .retired(retired)
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #3;
    endtask

    // Checks the FETCH cycle of a new instruction, then moves into DECODE.
    task automatic begin_instr(input logic [5:0] op, input logic [5:0] fn, input logic [31:0] exp_ret);
        opCode = op;
        func   = fn;
        #1;
        check_eq("fetch.state",   32'(state), 0);
        check_eq("fetch.irWrite", 32'(irWriteEn), 1);
        check_eq("fetch.retired", 32'(retired), exp_ret);
        step();
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset = 1'b0; opCode = '0; func = '0; equalAlu = 1'b0; memReady = 1'b0;
        repeat (2) @(posedge clk);
        #4;
        check_eq("rst.state",      32'(state), 0);
        check_eq("rst.irWrite",    32'(irWriteEn), 0);
        check_eq("rst.pcWrite",    32'(pcWriteEn), 0);
        check_eq("rst.retired",    32'(retired), 0);
        check_eq("rst.memTimeout", 32'(memTimeout), 0);
        reset = 1'b1;

        // addu
        begin_instr(6'h00, 6'h21, 0);
        check_eq("addu.dec.state",  32'(state), 1);
        check_eq("addu.aluOp",      32'(aluOp), 0);
        check_eq("addu.aluInOp",    32'(aluInOp), 1);
        check_eq("addu.dec.pc",     32'(pcWriteEn), 0);
        step(); #1;
        check_eq("addu.exe.state",  32'(state), 2);
        check_eq("addu.exe.regWe",  32'(regWriteEn), 0);
        step(); #1;
        check_eq("addu.wb.state",   32'(state), 4);
        check_eq("addu.wb.regWe",   32'(regWriteEn), 1);
        check_eq("addu.wb.addrOp",  32'(grfWriteAddrOp), 1);
        check_eq("addu.wb.grfOp",   32'(grfWriteOp), 1);
        check_eq("addu.wb.pc",      32'(pcWriteEn), 1);
        check_eq("addu.wb.npc",     32'(npcSel), 0);
        check_eq("addu.wb.done",    32'(instrDone), 1);
        step();

        // lw, memReady low for 3 MEM cycles
        memReady = 1'b0;
        begin_instr(6'h23, 6'h00, 1);
        check_eq("lw.dec.ext",      32'(extOp), 1);
        step(); #1;
        check_eq("lw.exe.state",    32'(state), 2);
        for (int i = 0; i < 3; i++) begin
            step(); #1;
            check_eq("lw.mem.state",  32'(state), 3);
            check_eq("lw.mem.readEn", 32'(memReadEn), 1);
            check_eq("lw.mem.pc",     32'(pcWriteEn), 0);
        end
        step();
        memReady = 1'b1;
        #1;
        check_eq("lw.mem4.state",   32'(state), 3);
        check_eq("lw.mem4.readEn",  32'(memReadEn), 1);
        check_eq("lw.mem4.done",    32'(instrDone), 0);
        step();
        memReady = 1'b0;
        #1;
        check_eq("lw.wb.state",     32'(state), 4);
        check_eq("lw.wb.regWe",     32'(regWriteEn), 1);
        check_eq("lw.wb.grfOp",     32'(grfWriteOp), 0);
        check_eq("lw.wb.addrOp",    32'(grfWriteAddrOp), 0);
        step();

        // beq taken
        equalAlu = 1'b1;
        begin_instr(6'h04, 6'h00, 2);
        check_eq("beq.dec.aluOp",   32'(aluOp), 1);
        check_eq("beq.dec.aluIn",   32'(aluInOp), 1);
        check_eq("beq.dec.ext",     32'(extOp), 1);
        step(); #1;
        check_eq("beqT.exe.state",  32'(state), 2);
        check_eq("beqT.exe.npc",    32'(npcSel), 1);
        check_eq("beqT.exe.pc",     32'(pcWriteEn), 1);
        check_eq("beqT.exe.done",   32'(instrDone), 1);
        step();

        // beq not taken
        equalAlu = 1'b0;
        begin_instr(6'h04, 6'h00, 3);
        step(); #1;
        check_eq("beqN.exe.npc",    32'(npcSel), 0);
        check_eq("beqN.exe.pc",     32'(pcWriteEn), 1);
        step();

        // jal
        begin_instr(6'h03, 6'h00, 4);
        check_eq("jal.dec.state",   32'(state), 1);
        step(); #1;
        check_eq("jal.wb.state",    32'(state), 4);
        check_eq("jal.wb.grfOp",    32'(grfWriteOp), 3);
        check_eq("jal.wb.addrOp",   32'(grfWriteAddrOp), 2);
        check_eq("jal.wb.npc",      32'(npcSel), 2);
        check_eq("jal.wb.regWe",    32'(regWriteEn), 1);
        step();

        // jr
        begin_instr(6'h00, 6'h08, 5);
        step(); #1;
        check_eq("jr.exe.npc",      32'(npcSel), 3);
        check_eq("jr.exe.pc",       32'(pcWriteEn), 1);
        check_eq("jr.exe.regWe",    32'(regWriteEn), 0);
        step();

        // illegal opcode
        begin_instr(6'h3F, 6'h00, 6);
        check_eq("illop.illegal",   32'(illegal), 1);
        check_eq("illop.pc",        32'(pcWriteEn), 1);
        check_eq("illop.npc",       32'(npcSel), 0);
        check_eq("illop.done",      32'(instrDone), 1);
        step();

        // illegal func
        begin_instr(6'h00, 6'h3F, 7);
        check_eq("illfn.illegal",   32'(illegal), 1);
        step();

        // nop
        begin_instr(6'h00, 6'h00, 8);
        check_eq("nop.illegal",     32'(illegal), 0);
        check_eq("nop.pc",          32'(pcWriteEn), 1);
        step();

        // ori
        begin_instr(6'h0D, 6'h00, 9);
        check_eq("ori.aluOp",       32'(aluOp), 2);
        check_eq("ori.ext",         32'(extOp), 0);
        check_eq("ori.aluIn",       32'(aluInOp), 0);
        check_eq("ori.addrOp",      32'(grfWriteAddrOp), 0);
        step(); step(); #1;
        check_eq("ori.wb.regWe",    32'(regWriteEn), 1);
        check_eq("ori.wb.grfOp",    32'(grfWriteOp), 1);
        step();

        // sw with memReady stuck low -> timeout abort
        memReady = 1'b0;
        begin_instr(6'h2B, 6'h00, 10);
        step();
        for (int i = 0; i < 3; i++) begin
            step(); #1;
            check_eq("swTO.mem.state", 32'(state), 3);
            check_eq("swTO.mem.wrEn",  32'(memWriteEn), 1);
            check_eq("swTO.mem.pc",    32'(pcWriteEn), 0);
        end
        step(); #1;
        check_eq("swTO.abort.state", 32'(state), 3);
        check_eq("swTO.abort.pc",    32'(pcWriteEn), 1);
        check_eq("swTO.abort.done",  32'(instrDone), 0);
        check_eq("swTO.abort.regWe", 32'(regWriteEn), 0);
        check_eq("swTO.abort.flag",  32'(memTimeout), 0);
        step(); #1;
        check_eq("swTO.after.flag",  32'(memTimeout), 1);

        // sw completing on first MEM cycle
        begin_instr(6'h2B, 6'h00, 10);
        step(); step();
        memReady = 1'b1;
        #1;
        check_eq("sw.mem.state",    32'(state), 3);
        check_eq("sw.mem.wrEn",     32'(memWriteEn), 1);
        check_eq("sw.mem.pc",       32'(pcWriteEn), 1);
        check_eq("sw.mem.done",     32'(instrDone), 1);
        step();
        memReady = 1'b0;

        // reset asserted during sw MEM
        begin_instr(6'h2B, 6'h00, 11);
        step(); step(); #1;
        check_eq("swRst.mem.state", 32'(state), 3);
        check_eq("swRst.mem.wrEn",  32'(memWriteEn), 1);
        reset = 1'b0;
        #1;
        check_eq("swRst.gate.wrEn", 32'(memWriteEn), 0);
        step(); #1;
        check_eq("swRst.state",     32'(state), 0);
        check_eq("swRst.wrEn",      32'(memWriteEn), 0);
        check_eq("swRst.retired",   32'(retired), 0);
        check_eq("swRst.flag",      32'(memTimeout), 0);
        reset = 1'b1;

        // retired counter wraps at 2^RETIRE_W
        for (int i = 0; i < 16; i++) begin
            begin_instr(6'h00, 6'h00, 32'(i));
            step();
        end
        #1;
        check_eq("wrap.retired",    32'(retired), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mc_ctrl.md
MC_CTRL -- requirements
Module: mc_ctrl

Interface
REQ-001 The block SHALL have these parameters: RETIRE_W, default 32, width of the retired-instruction counter; MEM_TIMEOUT, default 0, 0 = wait forever for memReady, otherwise the maximum number of MEM cycles.
REQ-002 The block SHALL have these ports:
- clk  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-low reset; reset==0 at a rising clk edge resets the block.
- opCode  in  6  instr[31:26] from the instruction register.
- func  in  6  instr[5:0].
- equalAlu  in  1  ALU equality flag.
- memReady  in  1  data memory access complete.
- irWriteEn  out  1  load instruction register.
- pcWriteEn  out  1  load PC.
- npcSel  out  2  0 = PC+4, 1 = branch, 2 = jump index, 3 = register (jr).
- regWriteEn  out  1  GRF write enable.
- memWriteEn  out  1  DM write enable.
- memReadEn  out  1  DM read strobe.
- aluOp  out  3  0 = ADD, 1 = SUB, 2 = OR.
- extOp  out  1  0 = zero-extend, 1 = sign-extend.
- aluInOp  out  2  0 = immediate, 1 = register.
- grfWriteOp  out  2  0 = mem, 1 = alu, 2 = lui, 3 = PC+4.
- grfWriteAddrOp  out  2  0 = rt, 1 = rd, 2 = $31.
- instrDone  out  1  final cycle of an instruction.
- illegal  out  1  one-cycle pulse on an unrecognised instruction.
- memTimeout  out  1  sticky; set when a MEM wait is aborted.
- state  out  3  current state, for debug.
- retired  out  RETIRE_W  count of completed instructions.

Function
REQ-003 The FSM SHALL have the states FETCH, DECODE, EXEC, MEM, WB.
REQ-004 Decoding SHALL use MIPS encodings: R-type 000000 with func addu 100001, subu 100011, jr 001000; ori 001101; lw 100011; sw 101011; beq 000100; lui 001111; jal 000011. An all-zero word SHALL be treated as a nop.
REQ-005 In FETCH, irWriteEn SHALL be 1 and the next state SHALL be DECODE.
REQ-006 Transitions out of DECODE SHALL be:
- jal -> WB.
- nop or illegal -> FETCH, with pcWriteEn=1 and npcSel=0.
- every other instruction -> EXEC.
REQ-007 Transitions out of EXEC SHALL be:
- addu, subu, ori, lui -> WB.
- lw, sw -> MEM.
- beq, jr -> FETCH; this is their final cycle.
REQ-008 MEM SHALL hold until memReady==1.
- During MEM, sw drives memWriteEn=1 and lw drives memReadEn=1.
- When memReady==1: lw -> WB; sw -> FETCH, and this is its final cycle.
REQ-009 WB SHALL drive regWriteEn=1 and SHALL always return to FETCH.
REQ-010 In every instruction's final cycle, pcWriteEn and instrDone SHALL be 1.
- npcSel = 1 for beq when equalAlu==1, 0 for beq otherwise; 2 for jal; 3 for jr; 0 for everything else.
- The final cycle is DECODE (nop/illegal), EXEC (beq, jr), MEM (sw) or WB (all others).
REQ-011 Latency in cycles SHALL be: nop/illegal 2; beq, jr, jal 3; addu, subu, ori, lui, sw 4; lw 5 plus the memReady wait cycles.
REQ-012 Datapath selects SHALL be held from DECODE through the final cycle:
- addu: aluOp ADD, aluInOp reg, grfWriteOp alu, grfWriteAddrOp rd.
- subu: aluOp SUB, aluInOp reg, grfWriteOp alu, grfWriteAddrOp rd.
- ori: aluOp OR, extOp 0, aluInOp imm, grfWriteOp alu, grfWriteAddrOp rt.
- lw, sw: aluOp ADD, extOp 1, aluInOp imm; lw additionally grfWriteOp mem, grfWriteAddrOp rt.
- beq: aluOp SUB, aluInOp reg, extOp 1.
- lui: grfWriteOp lui, grfWriteAddrOp rt.
- jal: grfWriteOp PC+4, grfWriteAddrOp $31.
REQ-013 Unused selects SHALL be 0, and every write enable SHALL be 0 outside the states listed above.
REQ-014 illegal SHALL pulse in DECODE for an unrecognised opcode, or for opcode 000000 with an unknown func and a nonzero word.
REQ-015 When MEM_TIMEOUT is nonzero, a MEM state that lasts MEM_TIMEOUT cycles without memReady SHALL:
- abort to FETCH with pcWriteEn=1, npcSel=0;
- set memTimeout;
- not assert regWriteEn;
- not count as retired.
REQ-016 retired SHALL increment by 1 on each instrDone, including nop and illegal, and SHALL wrap modulo 2^RETIRE_W.
REQ-017 All outputs SHALL be a Moore decode of state, opCode, func, equalAlu, and the MEM wait counter; no output SHALL be combinational on memReady except the MEM exit cycle's pcWriteEn/instrDone.

Reset
REQ-018 On reset==0, the block SHALL set state=FETCH, retired=0, memTimeout=0, and clear the MEM wait counter.
REQ-019 Reset asserted mid-instruction, including during MEM, SHALL abandon the instruction with no pending write.
REQ-020 While reset==0, all write enables and irWriteEn SHALL be 0.

Structure
REQ-021 The package mc_ctrl_pkg SHALL hold the state encoding, opcode and func constants, and the aluOp, npcSel, grfWriteOp, grfWriteAddrOp and aluInOp values.
REQ-022 The block SHALL contain one combinational sub-module, mc_decode, which maps opCode/func to an instruction-class one-hot plus an illegal flag.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- addu (func 100001): states FETCH, DECODE, EXEC, WB; in WB regWriteEn=1, grfWriteAddrOp=1, pcWriteEn=1, npcSel=0; retired 0 -> 1.
- lw with memReady low for 3 cycles: MEM lasts 4 cycles with memReadEn=1; WB follows; total 8 cycles.
- beq with equalAlu=1: npcSel=1 in EXEC; with equalAlu=0: npcSel=0; both take 3 cycles.
- jal: FETCH, DECODE, WB; in WB grfWriteOp=3, grfWriteAddrOp=2, npcSel=2.
- Opcode 111111: illegal pulse in DECODE, pcWriteEn=1, back to FETCH after 2 cycles; with MEM_TIMEOUT=4 and sw with memReady stuck low: abort after 4 MEM cycles, memTimeout=1, retired unchanged.
- reset=0 asserted during MEM of sw: next cycle state=FETCH, memWriteEn=0, retired=0.
